// File: rtl/elevator_call_scheduler.sv
// rtl/elevator_call_scheduler.sv - SCAN call scheduler for a 4-floor car: pending set, target floor, door dwell
module elevator_call_scheduler #(
    parameter int DWELL_CYCLES = 8,
    parameter int DWELL_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] call_btn,
    input  logic [3:0] cur_floor,
    output logic [3:0] req_floor,
    output logic [3:0] pending,
    output logic       door_open,
    output logic       dir_up,
    output logic       moving,
    output logic       fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2,
        S_DOOR = 2'd3
    } state_t;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    state_t             state_q, state_d;
    logic [3:0]         pending_q, pending_d;
    logic               dir_up_q, dir_up_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               door_open_q, door_open_d;
    logic               moving_q, moving_d;

    logic [3:0] above_mask;
    logic [3:0] below_mask;
    logic [3:0] up_cands;
    logic [3:0] down_cands;
    logic [3:0] up_pick;
    logic [3:0] down_pick;
    logic [3:0] clr;
    logic       here;
    logic       above;
    logic       below;
    logic       last_dwell;
    logic       fault_w;

    // Floor masks strictly above / strictly below the car position.
    always_comb begin
        above_mask = '0;
        below_mask = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (j < i) above_mask[i] = above_mask[i] | cur_floor[j];
                if (j > i) below_mask[i] = below_mask[i] | cur_floor[j];
            end
        end
    end

    // Classify pending calls relative to the car and pick the nearest one each way.
    always_comb begin
        fault_w    = (cur_floor == 4'd0) || ((cur_floor & (cur_floor - 4'd1)) != 4'd0);
        here       = |(pending_q & cur_floor);
        up_cands   = pending_q & above_mask;
        down_cands = pending_q & below_mask;
        above      = |up_cands;
        below      = |down_cands;
        up_pick    = '0;
        down_pick  = '0;
        // Lowest candidate above: scan high to low so the last hit wins.
        for (int i = 3; i >= 0; i--) begin
            if (up_cands[i]) up_pick = 4'(1 << i);
        end
        // Highest candidate below: scan low to high so the last hit wins.
        for (int i = 0; i < 4; i++) begin
            if (down_cands[i]) down_pick = 4'(1 << i);
        end
        last_dwell = (state_q == S_DOOR) && (cnt_q == DWELL_LAST);
    end

    // Target floor for the stepper; a bad position reading sends the car home.
    always_comb begin
        req_floor = cur_floor;
        if (fault_w) begin
            req_floor = 4'b0001;
        end else if (state_q == S_UP && up_pick != 4'd0) begin
            req_floor = up_pick;
        end else if (state_q == S_DOWN && down_pick != 4'd0) begin
            req_floor = down_pick;
        end
    end

    // Pending set: the served floor is cleared only on the final dwell cycle, new presses win.
    always_comb begin
        clr       = (last_dwell && !fault_w) ? cur_floor : 4'd0;
        pending_d = (pending_q & ~clr) | call_btn;
    end

    // SCAN next-state: hold direction while calls remain ahead, reverse only at a stop.
    always_comb begin
        state_d  = state_q;
        dir_up_d = dir_up_q;
        cnt_d    = cnt_q;
        if (fault_w) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (here) begin
                        state_d = S_DOOR;
                        cnt_d   = '0;
                    end else if (above) begin
                        state_d  = S_UP;
                        dir_up_d = 1'b1;
                    end else if (below) begin
                        state_d  = S_DOWN;
                        dir_up_d = 1'b0;
                    end
                end
                S_UP, S_DOWN: begin
                    if (here) begin
                        state_d = S_DOOR;
                        cnt_d   = '0;
                    end
                end
                S_DOOR: begin
                    cnt_d = cnt_q + DWELL_W'(1);
                    if (last_dwell) begin
                        cnt_d = '0;
                        if (dir_up_q && above) begin
                            state_d = S_UP;
                        end else if (!dir_up_q && below) begin
                            state_d = S_DOWN;
                        end else if (above) begin
                            state_d  = S_UP;
                            dir_up_d = 1'b1;
                        end else if (below) begin
                            state_d  = S_DOWN;
                            dir_up_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        door_open_d = (state_d == S_DOOR);
        moving_d    = (state_d == S_UP) || (state_d == S_DOWN);
    end

    // State, pending set, direction, dwell counter and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pending_q   <= '0;
            dir_up_q    <= 1'b1;
            cnt_q       <= '0;
            door_open_q <= 1'b0;
            moving_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            dir_up_q    <= dir_up_d;
            cnt_q       <= cnt_d;
            door_open_q <= door_open_d;
            moving_q    <= moving_d;
        end
    end

    assign pending   = pending_q;
    assign door_open = door_open_q;
    assign dir_up    = dir_up_q;
    assign moving    = moving_q;
    assign fault     = fault_w;

endmodule
